// File: rtl/regfile_mp.sv
// Multi-port integer register file with a busy scoreboard.
//
// Provides NRD registered read ports and two write ports: A for ALU writeback and B for
// load writeback. On an address collision port A wins. When BYPASS is set, a read of a
// register that is written in the same cycle returns the new data. A per-register busy bit
// marks registers whose producer has issued but not yet written back. Reset is asynchronous
// and active-high, and it clears every register and every busy bit.
//
// Ports
//   clk_i       clock; all state updates on the rising edge
//   rst_i       asynchronous active-high reset
//   rd_addr_i   NRD packed read addresses, port i at [i*AW +: AW]
//   rd_data_o   NRD packed registered read data, port i at [i*XLEN +: XLEN]
//   rd_busy_o   registered post-edge busy flag of each addressed register
//   wa_*_i      write port A (ALU writeback): enable, address, data
//   wb_*_i      write port B (load writeback): enable, address, data
//   iss_en_i    mark iss_addr_i busy (an instruction writing it has issued)
//   flush_i     clear every busy bit; overrides a same-cycle issue
//   any_busy_o  registered OR of all busy bits
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                wa_en_i,
    input  logic [AW-1:0]       wa_addr_i,
    input  logic [XLEN-1:0]     wa_data_i,
    input  logic                wb_en_i,
    input  logic [AW-1:0]       wb_addr_i,
    input  logic [XLEN-1:0]     wb_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                flush_i,
    output logic                any_busy_o
);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]    busy_q, busy_d;
    logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NRD-1:0]      rd_busy_q, rd_busy_d;
    logic                any_busy_q, any_busy_d;

    logic wa_ok, wb_ok, wb_win, iss_ok;

    // An address is real storage when it is in range and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        wa_ok  = wa_en_i && addr_ok(wa_addr_i);
        wb_ok  = wb_en_i && addr_ok(wb_addr_i);
        // Port B is dropped when port A writes the same register.
        wb_win = wb_ok && !(wa_ok && (wa_addr_i == wb_addr_i));
        iss_ok = iss_en_i && addr_ok(iss_addr_i);
    end

    always_comb begin
        for (int r = 0; r < int'(NREGS); r++) begin
            regs_d[r] = regs_q[r];
            if (wb_win && (wb_addr_i == AW'(r))) regs_d[r] = wb_data_i;
            if (wa_ok && (wa_addr_i == AW'(r))) regs_d[r] = wa_data_i;
        end
    end

    // Issue beats a same-cycle writeback to the same register, and flush beats everything.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < int'(NREGS); r++) begin
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (iss_ok && (iss_addr_i == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((wa_ok && (wa_addr_i == AW'(r))) || (wb_ok && (wb_addr_i == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
        any_busy_d = |busy_d;
    end

    for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdata;
        logic            rbusy;

        assign ra = rd_addr_i[i*AW +: AW];

        always_comb begin
            rdata = '0;
            rbusy = 1'b0;
            if (addr_ok(ra)) begin
                for (int r = 0; r < int'(NREGS); r++) begin
                    if (ra == AW'(r)) begin
                        rdata = regs_q[r];
                        rbusy = busy_d[r];
                    end
                end
                if (BYPASS != 0) begin
                    if (wb_win && (wb_addr_i == ra)) rdata = wb_data_i;
                    if (wa_ok && (wa_addr_i == ra)) rdata = wa_data_i;
                end
            end
        end

        assign rd_data_d[i*XLEN +: XLEN] = rdata;
        assign rd_busy_d[i]              = rbusy;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= '0;
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_busy_q  <= '0;
            any_busy_q <= 1'b0;
        end else begin
            for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= regs_d[r];
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_busy_q  <= rd_busy_d;
            any_busy_q <= any_busy_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_busy_o  = rd_busy_q;
    assign any_busy_o = any_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp. It drives two instances from the same stimulus:
//   dut0: default configuration (32 registers, zero register, bypass on)
//   dut1: 24 registers, no zero register, bypass off; addresses 24..31 are out of range
// Every cycle an array-based reference model pushes its expected outputs into a queue, and
// a separate monitor pops and compares them one edge later.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic                wa_en, wb_en, iss_en, flush;
    logic [AW-1:0]       wa_addr, wb_addr, iss_addr;
    logic [XLEN-1:0]     wa_data, wb_data;
    logic [NRD*XLEN-1:0] rd_data0, rd_data1;
    logic [NRD-1:0]      rd_busy0, rd_busy1;
    logic                any_busy0, any_busy1;

    always #5 clk = ~clk;

    regfile_mp dut0 (
        .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data0),
        .rd_busy_o(rd_busy0), .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .iss_en_i(iss_en),
        .iss_addr_i(iss_addr), .flush_i(flush), .any_busy_o(any_busy0)
    );

    regfile_mp #(.NREGS(24), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data1),
        .rd_busy_o(rd_busy1), .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .iss_en_i(iss_en),
        .iss_addr_i(iss_addr), .flush_i(flush), .any_busy_o(any_busy1)
    );

    typedef struct {
        logic [NRD*XLEN-1:0] d;
        logic [NRD-1:0]      b;
        logic                a;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m_reg  [2][32];
    logic [31:0] m_busy [2];
    int          checks = 0;
    int          errors = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whether address a names real storage in instance k.
    function automatic bit ok(input int k, input int a);
        int nregs = (k == 0) ? 32 : 24;
        bit zr    = (k == 0);
        return (a < nregs) && !(zr && a == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = '0;
            for (int r = 0; r < 32; r++) m_reg[k][r] = '0;
        end
    endtask

    task automatic model_step(input int k, output exp_t e);
        bit          byp = (k == 0);
        bit          wa  = wa_en && ok(k, int'(wa_addr));
        bit          wb  = wb_en && ok(k, int'(wb_addr));
        logic [31:0] nb  = m_busy[k];
        if (flush) begin
            nb = '0;
        end else begin
            if (wa) nb[wa_addr] = 1'b0;
            if (wb) nb[wb_addr] = 1'b0;
            if (iss_en && ok(k, int'(iss_addr))) nb[iss_addr] = 1'b1;
        end
        for (int i = 0; i < NRD; i++) begin
            int a = int'(rd_addr[i*AW +: AW]);
            e.d[i*XLEN +: XLEN] = '0;
            e.b[i]              = 1'b0;
            if (ok(k, a)) begin
                if (byp && wa && int'(wa_addr) == a)      e.d[i*XLEN +: XLEN] = wa_data;
                else if (byp && wb && int'(wb_addr) == a) e.d[i*XLEN +: XLEN] = wb_data;
                else                                      e.d[i*XLEN +: XLEN] = m_reg[k][a];
                e.b[i] = nb[a];
            end
        end
        e.a = (nb != 0);
        // Apply B before A so A wins a collision.
        if (wb) m_reg[k][wb_addr] = wb_data;
        if (wa) m_reg[k][wa_addr] = wa_data;
        m_busy[k] = nb;
    endtask

    task automatic idle();
        rd_addr = '0;
        wa_en = 0; wa_addr = '0; wa_data = '0;
        wb_en = 0; wb_addr = '0; wb_data = '0;
        iss_en = 0; iss_addr = '0; flush = 0;
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        exp_t e;
        model_step(0, e);
        q0.push_back(e);
        model_step(1, e);
        q1.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_data0"}, 64'(rd_data0), 64'd0);
        cmp({tag, "_busy0"}, 64'(rd_busy0), 64'd0);
        cmp({tag, "_any0"},  64'(any_busy0), 64'd0);
        cmp({tag, "_data1"}, 64'(rd_data1), 64'd0);
        cmp({tag, "_busy1"}, 64'(rd_busy1), 64'd0);
        cmp({tag, "_any1"},  64'(any_busy1), 64'd0);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without an edge.
    task automatic rst_pulse();
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        #1 rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp("dut0_rd_data", 64'(rd_data0), 64'(e.d));
                cmp("dut0_rd_busy", 64'(rd_busy0), 64'(e.b));
                cmp("dut0_any_busy", 64'(any_busy0), 64'(e.a));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("dut1_rd_data", 64'(rd_data1), 64'(e.d));
                cmp("dut1_rd_busy", 64'(rd_busy1), 64'(e.b));
                cmp("dut1_any_busy", 64'(any_busy1), 64'(e.a));
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("init_rst");
        rst = 1'b0;

        // Write then read back on port 1.
        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; step();
        idle(); rd_addr[AW +: AW] = 5; step();
        // Same-cycle bypass from port B.
        idle(); wb_en = 1; wb_addr = 7; wb_data = 32'h1234; rd_addr[0 +: AW] = 7; step();
        // Write collision on x3, both ports reading it.
        idle(); wa_en = 1; wa_addr = 3; wa_data = 32'hA; wb_en = 1; wb_addr = 3;
        wb_data = 32'hB; rd_addr = {5'd3, 5'd3}; step();
        idle(); rd_addr = {5'd3, 5'd3}; step();
        // Scoreboard sequence on x9.
        idle(); iss_en = 1; iss_addr = 9; rd_addr[0 +: AW] = 9; step();
        idle(); iss_en = 1; iss_addr = 9; wa_en = 1; wa_addr = 9; wa_data = 32'h99;
        rd_addr[0 +: AW] = 9; step();
        idle(); wb_en = 1; wb_addr = 9; wb_data = 32'h77; rd_addr[0 +: AW] = 9; step();
        idle(); iss_en = 1; iss_addr = 4; rd_addr[0 +: AW] = 4; step();
        idle(); iss_en = 1; iss_addr = 6; flush = 1; rd_addr = {5'd6, 5'd4}; step();
        // Register 0 writes and issue.
        idle(); wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF; iss_en = 1; step();
        idle(); rd_addr = '0; step();
        // Address beyond NREGS of dut1.
        idle(); wa_en = 1; wa_addr = 26; wa_data = 32'h2626; iss_en = 1; iss_addr = 26;
        rd_addr[0 +: AW] = 26; step();
        idle(); rd_addr = {5'd26, 5'd26}; step();
        // Reset mid-operation, then a write in the deasserting cycle.
        idle(); iss_en = 1; iss_addr = 12; wa_en = 1; wa_addr = 2; wa_data = 32'h55; step();
        idle();
        rst_pulse();
        wa_en = 1; wa_addr = 12; wa_data = 32'hC0DE; rd_addr = {5'd12, 5'd2}; step();
        idle(); rd_addr = {5'd12, 5'd2}; step();

        for (int n = 0; n < 600; n++) begin
            rd_addr  = {rand_addr(), rand_addr()};
            wa_en    = 1'($urandom_range(0, 1));
            wa_addr  = rand_addr();
            wa_data  = $urandom();
            wb_en    = 1'($urandom_range(0, 1));
            wb_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : rand_addr();
            wb_data  = $urandom();
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = ($urandom_range(0, 3) == 0) ? wa_addr : rand_addr();
            flush    = ($urandom_range(0, 19) == 0);
            step();
        end

        idle();
        @(posedge clk);
        #2;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d/%0d expected 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
